// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and shared-ALU signals of alu_arbiter.
// Modports: slave = arbiter side, master = requesters plus the shared ALU.
//   req0/req1 : valid/ready operation handshake with a, b, op
//   rsp0/rsp1 : valid/ready result handshake with res, zero, ovf
//   alu_*     : operands out to the shared ALU, result and flags back in
//   busy      : arbiter not idle;  gnt_id : owner of the current operation
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_res;
    logic        rsp0_zero;
    logic        rsp0_ovf;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_res;
    logic        rsp1_zero;
    logic        rsp1_ovf;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_ovf;

    logic        busy;
    logic        gnt_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_zero, rsp0_ovf,
        output rsp1_valid, rsp1_res, rsp1_zero, rsp1_ovf,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_res, alu_zero, alu_ovf,
        output busy, gnt_id
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_zero, rsp0_ovf,
        input  rsp1_valid, rsp1_res, rsp1_zero, rsp1_ovf,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_res, alu_zero, alu_ovf,
        input  busy, gnt_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Ports: clk, rst (async, active high), bus (alu_arbiter_if.slave).
// Flow: IDLE grants and accepts, EXEC lets the ALU settle for one cycle,
// RESP holds the captured result for the owner until it is consumed.
// RR_EN=1 round-robin between requesters, RR_EN=0 req0 has priority.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        ptr_q;
    logic        gnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [31:0] res_q;
    logic        zero_q;
    logic        ovf_q;

    logic        grant;
    logic        idle;
    logic        accept;
    logic        rsp_done;
    logic        ovf_op;
    logic        in_resp;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [2:0]  sel_op;

    // Grant. On a tie round-robin favours whoever did not win last;
    // a lone requester always wins regardless of the pointer.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = RR_EN ? ~ptr_q : 1'b0;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is masked during reset so nothing is offered while rst is
    // high, even before the state register is observed at IDLE.
    assign idle   = (state_q == IDLE) && !rst;
    assign bus.req0_ready = idle && bus.req0_valid && !grant;
    assign bus.req1_ready = idle && bus.req1_valid && grant;
    assign accept = bus.req0_ready || bus.req1_ready;

    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;
    assign sel_op = grant ? bus.req1_op : bus.req0_op;

    assign rsp_done = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only add and sub produce a meaningful overflow; anything the ALU
    // reports for other codes is dropped.
    assign ovf_op = (op_q == 3'b010) || (op_q == 3'b110);

    // Operand registers are only written on accept, so the ALU inputs
    // keep the last transaction's values while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= 1'b1;
            gnt_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q <= grant;
                gnt_q <= grant;
                a_q   <= sel_a;
                b_q   <= sel_b;
                op_q  <= sel_op;
            end
            if (state_q == EXEC) begin
                res_q  <= bus.alu_res;
                zero_q <= bus.alu_zero;
                ovf_q  <= ovf_op && bus.alu_ovf;
            end
        end
    end

    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
    assign bus.alu_op = op_q;

    // Responses are steered to the owner only while in RESP; the other
    // requester's response lines stay at zero.
    assign in_resp = (state_q == RESP);

    assign bus.rsp0_valid = in_resp && !gnt_q;
    assign bus.rsp0_res   = bus.rsp0_valid ? res_q : '0;
    assign bus.rsp0_zero  = bus.rsp0_valid && zero_q;
    assign bus.rsp0_ovf   = bus.rsp0_valid && ovf_q;

    assign bus.rsp1_valid = in_resp && gnt_q;
    assign bus.rsp1_res   = bus.rsp1_valid ? res_q : '0;
    assign bus.rsp1_zero  = bus.rsp1_valid && zero_q;
    assign bus.rsp1_ovf   = bus.rsp1_valid && ovf_q;

    assign bus.busy   = (state_q != IDLE);
    assign bus.gnt_id = gnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: round-robin and fixed-priority arbiters driven in parallel
// against a transaction-level model, plus directed literal scenarios.
module tb_alu_arbiter;

    logic clk;
    logic rst;

    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;

    int checks;
    int failures;

    alu_arbiter_if bus_rr();
    alu_arbiter_if bus_fp();

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return ~(a | b);
            3'd5: return a >> b[10:6];
            3'd6: return a - b;
            default: return {31'd0, a < b};
        endcase
    endfunction

    // Real signed overflow for add/sub; other codes report 1 on purpose
    // so a missing mask in the arbiter shows up.
    function automatic logic ovf_fn(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        logic [31:0] s;
        if (op == 3'd2) begin
            s = a + b;
            return (a[31] == b[31]) && (s[31] != a[31]);
        end
        if (op == 3'd6) begin
            s = a - b;
            return (a[31] != b[31]) && (s[31] != a[31]);
        end
        return 1'b1;
    endfunction

    assign bus_rr.req0_valid = v0;
    assign bus_rr.req0_a     = a0;
    assign bus_rr.req0_b     = b0;
    assign bus_rr.req0_op    = op0;
    assign bus_rr.req1_valid = v1;
    assign bus_rr.req1_a     = a1;
    assign bus_rr.req1_b     = b1;
    assign bus_rr.req1_op    = op1;
    assign bus_rr.rsp0_ready = rr0;
    assign bus_rr.rsp1_ready = rr1;
    assign bus_rr.alu_res  = alu_fn(bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b);
    assign bus_rr.alu_zero = (bus_rr.alu_res == 32'd0);
    assign bus_rr.alu_ovf  = ovf_fn(bus_rr.alu_op, bus_rr.alu_a, bus_rr.alu_b);

    assign bus_fp.req0_valid = v0;
    assign bus_fp.req0_a     = a0;
    assign bus_fp.req0_b     = b0;
    assign bus_fp.req0_op    = op0;
    assign bus_fp.req1_valid = v1;
    assign bus_fp.req1_a     = a1;
    assign bus_fp.req1_b     = b1;
    assign bus_fp.req1_op    = op1;
    assign bus_fp.rsp0_ready = rr0;
    assign bus_fp.rsp1_ready = rr1;
    assign bus_fp.alu_res  = alu_fn(bus_fp.alu_op, bus_fp.alu_a, bus_fp.alu_b);
    assign bus_fp.alu_zero = (bus_fp.alu_res == 32'd0);
    assign bus_fp.alu_ovf  = ovf_fn(bus_fp.alu_op, bus_fp.alu_a, bus_fp.alu_b);

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        v0;
        logic [31:0] res0;
        logic        z0;
        logic        o0;
        logic        v1;
        logic [31:0] res1;
        logic        z1;
        logic        o1;
        logic [31:0] aa;
        logic [31:0] ab;
        logic [2:0]  aop;
        logic        busy;
        logic        gnt;
    } obs_t;

    obs_t obs [2];

    assign obs[0] = {bus_rr.req0_ready, bus_rr.req1_ready,
                     bus_rr.rsp0_valid, bus_rr.rsp0_res,
                     bus_rr.rsp0_zero, bus_rr.rsp0_ovf,
                     bus_rr.rsp1_valid, bus_rr.rsp1_res,
                     bus_rr.rsp1_zero, bus_rr.rsp1_ovf,
                     bus_rr.alu_a, bus_rr.alu_b, bus_rr.alu_op,
                     bus_rr.busy, bus_rr.gnt_id};
    assign obs[1] = {bus_fp.req0_ready, bus_fp.req1_ready,
                     bus_fp.rsp0_valid, bus_fp.rsp0_res,
                     bus_fp.rsp0_zero, bus_fp.rsp0_ovf,
                     bus_fp.rsp1_valid, bus_fp.rsp1_res,
                     bus_fp.rsp1_zero, bus_fp.rsp1_ovf,
                     bus_fp.alu_a, bus_fp.alu_b, bus_fp.alu_op,
                     bus_fp.busy, bus_fp.gnt_id};

    // Transaction-level model: 0 idle, 1 executing, 2 holding a result.
    int          ph [2];
    logic        mg [2];
    logic        ml [2];
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic [2:0]  mo [2];

    logic watch_fp;
    logic fp_r1;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0;
            mg[i] = 1'b0;
            ml[i] = 1'b1;
            ma[i] = '0;
            mb[i] = '0;
            mo[i] = '0;
        end
    endtask

    function automatic logic grant_of(input int i);
        if (v0 && v1) return (i == 0) ? ~ml[i] : 1'b0;
        if (v1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t exp_of(input int i);
        obs_t e;
        logic g;
        logic [31:0] r;
        logic f;
        e = '0;
        g = grant_of(i);
        if (ph[i] == 0 && !rst) begin
            e.rdy0 = v0 && !g;
            e.rdy1 = v1 && g;
        end
        if (ph[i] == 2) begin
            r = alu_fn(mo[i], ma[i], mb[i]);
            f = (mo[i] == 3'd2 || mo[i] == 3'd6) && ovf_fn(mo[i], ma[i], mb[i]);
            if (!mg[i]) begin
                e.v0 = 1'b1; e.res0 = r; e.z0 = (r == 0); e.o0 = f;
            end else begin
                e.v1 = 1'b1; e.res1 = r; e.z1 = (r == 0); e.o1 = f;
            end
        end
        e.aa   = ma[i];
        e.ab   = mb[i];
        e.aop  = mo[i];
        e.busy = (ph[i] != 0);
        e.gnt  = mg[i];
        return e;
    endfunction

    task automatic model_step();
        logic g;
        for (int i = 0; i < 2; i++) begin
            case (ph[i])
                0: begin
                    g = grant_of(i);
                    if (g ? v1 : v0) begin
                        mg[i] = g;
                        ml[i] = g;
                        ma[i] = g ? a1 : a0;
                        mb[i] = g ? b1 : b0;
                        mo[i] = g ? op1 : op0;
                        ph[i] = 1;
                    end
                end
                1: ph[i] = 2;
                default: if (mg[i] ? rr1 : rr0) ph[i] = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        obs_t e;
        string p;
        for (int i = 0; i < 2; i++) begin
            e = exp_of(i);
            p = (i == 0) ? "rr" : "fp";
            chk({p, "_ready"}, 128'({obs[i].rdy0, obs[i].rdy1}),
                128'({e.rdy0, e.rdy1}));
            chk({p, "_rsp0"},
                128'({obs[i].v0, obs[i].res0, obs[i].z0, obs[i].o0}),
                128'({e.v0, e.res0, e.z0, e.o0}));
            chk({p, "_rsp1"},
                128'({obs[i].v1, obs[i].res1, obs[i].z1, obs[i].o1}),
                128'({e.v1, e.res1, e.z1, e.o1}));
            chk({p, "_alu"}, 128'({obs[i].aa, obs[i].ab, obs[i].aop}),
                128'({e.aa, e.ab, e.aop}));
            chk({p, "_ctl"}, 128'({obs[i].busy, obs[i].gnt}),
                128'({e.busy, e.gnt}));
        end
        if (watch_fp && obs[1].rdy1) fp_r1 = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        @(negedge clk);
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", 128'({obs[0].busy, obs[1].busy}), 128'(0));
        chk("rst_valid", 128'({obs[0].v0, obs[0].v1, obs[1].v0, obs[1].v1}),
            128'(0));
        chk("rst_ready", 128'({obs[0].rdy0, obs[0].rdy1, obs[1].rdy0,
                               obs[1].rdy1}), 128'(0));
        chk("rst_alu", 128'({obs[0].aa, obs[0].ab, obs[0].aop, obs[0].gnt}),
            128'(0));
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        watch_fp = 1'b0;
        fp_r1 = 1'b0;
        rst = 1'b1;
        idle_inputs();
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        model_reset();
        #1;
        chk("init_busy", 128'({obs[0].busy, obs[1].busy}), 128'(0));
        chk("init_alu", 128'({obs[0].aa, obs[0].ab, obs[0].aop}), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: req0 add 5+3.
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 3'b010;
        cycle();
        v0 = 1'b0;
        chk("s1_busy_exec", 128'(obs[0].busy), 128'(1));
        chk("s1_no_early_rsp", 128'(obs[0].v0), 128'(0));
        cycle();
        chk("s1_rsp0", 128'({obs[0].v0, obs[0].res0, obs[0].z0, obs[0].o0}),
            128'({1'b1, 32'd8, 1'b0, 1'b0}));
        cycle();
        chk("s1_idle", 128'(obs[0].busy), 128'(0));

        // Scenario 2/3: both requesters continuously valid.
        async_reset();
        watch_fp = 1'b1;
        v0 = 1'b1; a0 = 32'd7; b0 = 32'd7; op0 = 3'b110;
        v1 = 1'b1; a1 = 32'hF0; b1 = 32'h0F; op1 = 3'b000;
        cycle();
        chk("s2_gnt_a", 128'({obs[0].gnt, obs[1].gnt}), 128'(0));
        cycle();
        chk("s2_rsp0", 128'({obs[0].v0, obs[0].res0, obs[0].z0}),
            128'({1'b1, 32'd0, 1'b1}));
        cycle();
        cycle();
        chk("s2_gnt_b", 128'({obs[0].gnt, obs[1].gnt}), 128'({1'b1, 1'b0}));
        cycle();
        chk("s2_rsp1", 128'({obs[0].v1, obs[0].res1, obs[0].z1, obs[0].v0}),
            128'({1'b1, 32'd0, 1'b1, 1'b0}));
        cycle();
        cycle();
        chk("s2_gnt_c", 128'({obs[0].gnt, obs[1].gnt}), 128'(0));
        idle_inputs();
        cycle();
        cycle();
        cycle();
        watch_fp = 1'b0;
        chk("s3_fp_req1_never_ready", 128'(fp_r1), 128'(0));

        // Scenario 4: backpressure on rsp1, shift right by 31.
        async_reset();
        v1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'h0000_07C0; op1 = 3'b101;
        rr1 = 1'b0; rr0 = 1'b0;
        cycle();
        v0 = 1'b1;
        a0 = 32'd1; b0 = 32'd2; op0 = 3'b001;
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("s4_hold", 128'({obs[0].v1, obs[0].res1, obs[0].rdy0,
                                 obs[0].rdy1}),
                128'({1'b1, 32'd1, 1'b0, 1'b0}));
            cycle();
        end
        rr1 = 1'b1;
        chk("s4_release", 128'({obs[0].v1, obs[0].res1}), 128'({1'b1, 32'd1}));
        cycle();
        chk("s4_accept_next", 128'({obs[0].rdy0, obs[0].rdy1}),
            128'({1'b1, 1'b0}));
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Scenario 5: overflow masking.
        v0 = 1'b1; a0 = 32'h7FFF_FFFF; b0 = 32'd1; op0 = 3'b010;
        cycle();
        v0 = 1'b0;
        cycle();
        chk("s5_add_ovf", 128'({obs[0].res0, obs[0].o0}),
            128'({32'h8000_0000, 1'b1}));
        cycle();
        v0 = 1'b1; op0 = 3'b011;
        cycle();
        v0 = 1'b0;
        cycle();
        chk("s5_xor_no_ovf", 128'({obs[0].res0, obs[0].o0}),
            128'({32'h7FFF_FFFE, 1'b0}));
        cycle();

        // Scenario 6: reset during EXEC, then during RESP.
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd4; op0 = 3'b010;
        cycle();
        async_reset();
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();
        v0 = 1'b1; rr0 = 1'b0;
        cycle();
        v0 = 1'b0;
        cycle();
        chk("s6_in_resp", 128'(obs[0].v0), 128'(1));
        async_reset();
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("s6_tie_req0", 128'({obs[0].rdy0, obs[0].rdy1}),
            128'({1'b1, 1'b0}));
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            v0  = ($urandom_range(0, 99) < 55);
            v1  = ($urandom_range(0, 99) < 55);
            rr0 = ($urandom_range(0, 99) < 60);
            rr1 = ($urandom_range(0, 99) < 60);
            a0  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
